// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with several instruction-memory requests in flight and a DEPTH-entry prefetch queue.
// A redirect flushes the queue and counts the requests still in flight so their responses are dropped.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [XLEN-1:0] NOP_INSTR  = 32'hC400_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            exc_redirect,
  input  logic            jr_redirect,
  input  logic [XLEN-1:0] jr_target,
  input  logic            jump_redirect,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_redirect,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall_D,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;

  logic            req_fire;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   inflight_next;
  logic [CW:0]     credit_sum;
  logic            push;
  logic            pop;

  // Queue entries plus outstanding requests never exceed DEPTH, so a push always has room.
  assign credit_sum     = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req_valid = !reset && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign push           = imem_rsp_valid && (drop_cnt == '0) && !redirect;
  assign pop            = !redirect && !stall_D && (q_count != '0);

  always_comb begin
    redirect        = 1'b1;
    redirect_target = EXC_VECTOR;
    if (exc_redirect) begin
      redirect_target = EXC_VECTOR;
    end else if (jr_redirect) begin
      redirect_target = jr_target;
    end else if (jump_redirect) begin
      redirect_target = jump_target;
    end else if (branch_redirect) begin
      redirect_target = branch_target;
    end else begin
      redirect        = 1'b0;
      redirect_target = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_count  <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      instrD   <= NOP_INSTR;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        // Everything still outstanding after this edge belongs to the old path.
        pc       <= redirect_target;
        resp_pc  <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        q_count  <= '0;
        drop_cnt <= inflight_next;
        instrD   <= NOP_INSTR;
        pcplus4D <= '0;
        validD   <= 1'b0;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        q_count <= q_count + CW'(push) - CW'(pop);
        if (!stall_D) begin
          if (pop) begin
            instrD   <= q_instr[rd_ptr];
            pcplus4D <= q_pc[rd_ptr] + XLEN'(4);
            validD   <= 1'b1;
          end else begin
            instrD   <= NOP_INSTR;
            pcplus4D <= '0;
            validD   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: random-latency memory model, expected-fetch queue scoreboard,
// and directed scenarios for streaming, stall fill, redirects and mid-stream reset.
module tb_fetch_prefetch_unit;

  localparam int          XLEN       = 32;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
  localparam logic [31:0] NOP        = 32'hC400_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        exc_redirect;
  logic        jr_redirect;
  logic [31:0] jr_target;
  logic        jump_redirect;
  logic [31:0] jump_target;
  logic        branch_redirect;
  logic [31:0] branch_target;
  logic        stall_D;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;

  fetch_prefetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC),
    .EXC_VECTOR(EXC_VECTOR), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .exc_redirect(exc_redirect),
    .jr_redirect(jr_redirect), .jr_target(jr_target),
    .jump_redirect(jump_redirect), .jump_target(jump_target),
    .branch_redirect(branch_redirect), .branch_target(branch_target),
    .stall_D(stall_D),
    .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  pend_t       pending[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] salt = 32'h0;
  int          cyc = 0;
  int          fire_cnt = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        prev_load = 1'b0;
  logic        prev_redir = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: in-order responses, each at least one cycle after acceptance; instruction = addr ^ salt.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        imem_rsp_valid = 1'b0;
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pending[0].addr ^ salt;
        void'(pending.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Reference model and monitor. Every request accepted since the last redirect/reset must reach
  // decode in order; anything accepted earlier must never appear.
  always @(negedge clk) begin : model
    logic        redir;
    logic        fire;
    logic [31:0] e;
    pend_t       p;
    int          lat;
    if (reset) begin
      exp_q.delete();
      pending.delete();
      model_pc   = RESET_PC;
      prev_load  = 1'b0;
      prev_redir = 1'b0;
      fire_cnt   = 0;
      last_due   = 0;
    end else begin
      if (prev_redir) begin
        check("redirect_bubble_valid", {31'b0, validD}, 32'd0);
        check("redirect_bubble_instr", instrD, NOP);
      end else if (prev_load && validD) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_decode: got pcplus4D %h, expected no instruction", pcplus4D);
        end else begin
          e = exp_q.pop_front();
          check("decode_pcplus4", pcplus4D, e + 32'd4);
          check("decode_instr", instrD, e ^ salt);
        end
      end
      redir = exc_redirect | jr_redirect | jump_redirect | branch_redirect;
      fire  = imem_req_valid & imem_req_ready;
      if (fire) begin
        check("req_addr", imem_addr, model_pc);
        fire_cnt++;
        lat = int'($urandom_range(lat_max, lat_min));
        p.addr = imem_addr;
        p.due  = cyc + lat;
        if (p.due < last_due) p.due = last_due;
        last_due = p.due;
        pending.push_back(p);
      end
      if (redir) begin
        model_pc = exc_redirect ? EXC_VECTOR : jr_redirect ? jr_target :
                   jump_redirect ? jump_target : branch_target;
        exp_q.delete();
      end else if (fire) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      prev_load  = !stall_D && !redir;
      prev_redir = redir;
    end
  end

  task automatic wait_valid(input string name, output logic got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (validD) got = 1'b1;
    end
    check(name, {31'b0, got}, 32'd1);
  endtask

  task automatic do_reset(input logic [31:0] new_salt);
    reset = 1'b1;
    salt  = new_salt;
    step();
    step();
  endtask

  initial begin : stim
    logic got;
    reset = 1'b1;
    imem_req_ready = 1'b0;
    exc_redirect = 1'b0; jr_redirect = 1'b0; jump_redirect = 1'b0; branch_redirect = 1'b0;
    jr_target = 32'h0; jump_target = 32'h0; branch_target = 32'h0;
    stall_D = 1'b0;
    step();
    step();
    check("rst_instrD", instrD, NOP);
    check("rst_pcplus4D", pcplus4D, 32'h0);
    check("rst_validD", {31'b0, validD}, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);

    // Streaming, 1-cycle memory, instr = addr.
    imem_req_ready = 1'b1;
    reset = 1'b0;
    step();
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      check("stream_validD", {31'b0, validD}, 32'd1);
    end

    // Stall from reset: exactly DEPTH requests, then a gapless drain.
    stall_D = 1'b1;
    do_reset(32'h0);
    reset = 1'b0;
    repeat (10) step();
    check("stall_fire_count", fire_cnt, DEPTH);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    stall_D = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_release_validD", {31'b0, validD}, 32'd1);
    end

    // Branch with several requests outstanding, 3-cycle memory.
    lat_min = 3; lat_max = 3;
    do_reset($urandom);
    reset = 1'b0;
    repeat (8) step();
    branch_redirect = 1'b1; branch_target = 32'h100;
    step();
    branch_redirect = 1'b0;
    wait_valid("branch_found", got);
    check("branch_pcplus4", pcplus4D, 32'h104);

    // Simultaneous exc/jr/branch: exception wins.
    exc_redirect = 1'b1;
    jr_redirect = 1'b1; jr_target = 32'h200;
    branch_redirect = 1'b1; branch_target = 32'h300;
    step();
    exc_redirect = 1'b0; jr_redirect = 1'b0; branch_redirect = 1'b0;
    check("prio_imem_addr", imem_addr, EXC_VECTOR);
    check("prio_instrD", instrD, NOP);
    check("prio_validD", {31'b0, validD}, 32'd0);

    // Ready toggling 1,0,0,1 with jumps landing on response cycles.
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = (i % 4 == 0) || (i % 4 == 3);
      jump_redirect  = (i % 4 == 3);
      jump_target    = 32'h400 + 32'(i * 16);
      step();
    end
    jump_redirect = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid("toggle_recover", got);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    do_reset($urandom);
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [31:0] t;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      stall_D        = ($urandom_range(3, 0) == 0);
      r = int'($urandom_range(15, 0));
      t = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      exc_redirect    = (r == 0) || (r == 4 && $urandom_range(1, 0) == 1);
      jr_redirect     = !stall_D && ((r == 1) || (r == 4 && $urandom_range(1, 0) == 1));
      jump_redirect   = (r == 2) || (r == 4 && $urandom_range(1, 0) == 1);
      branch_redirect = (r == 3) || (r == 4);
      jr_target     = t;
      jump_target   = t ^ 32'h0000_1000;
      branch_target = t ^ 32'h0002_0000;
      step();
    end
    exc_redirect = 1'b0; jr_redirect = 1'b0; jump_redirect = 1'b0; branch_redirect = 1'b0;
    stall_D = 1'b0;
    imem_req_ready = 1'b1;

    // Asynchronous reset mid-stream with requests outstanding and a partly filled queue.
    lat_min = 2; lat_max = 2;
    repeat (6) step();
    stall_D = 1'b1;
    repeat (2) step();
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_instrD", instrD, NOP);
    check("async_rst_pcplus4D", pcplus4D, 32'h0);
    check("async_rst_validD", {31'b0, validD}, 32'd0);
    check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("async_rst_imem_addr", imem_addr, RESET_PC);
    step();
    step();
    reset = 1'b0;
    stall_D = 1'b0;
    wait_valid("post_rst_found", got);
    check("post_rst_pcplus4", pcplus4D, RESET_PC + 32'd4);
    check("post_rst_instr", instrD, RESET_PC ^ salt);

    // Drain: nothing accepted may be lost.
    imem_req_ready = 1'b0;
    repeat (15) step();
    check("drain_expected_left", exp_q.size(), 32'd0);
    check("drain_pending_left", pending.size(), 32'd0);
    check("drain_validD", {31'b0, validD}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
